sseg_scan_driver: RTL
=====================

# sseg_scan_driver

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display, consuming the 16-bit, 4-digit code word produced by the reaction timer and other front-panel blocks. It double-buffers the code word so updates never tear mid-frame, decodes digit codes including the panel glyphs (blank, H, I, L, E, '-'), and applies leading-zero suppression, per-digit decimal points and 8-level brightness PWM. It sits between the control FSMs and the an/sseg pins.

## Interface
- SLICE_CYCLES, 12500: clock cycles per brightness slice. One digit period is 8 slices, which is 1 ms at 100 MHz.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- display_data  in  16  code word, one nibble per digit. [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
- update  in  1  single-cycle strobe; captures display_data, dp_mask and blank_lz into the pending buffer.
- dp_mask  in  4  decimal-point enable per digit, bit i belongs to digit i.
- blank_lz  in  1  enables leading-zero suppression.
- brightness  in  3  on-time of 0..7, giving (brightness+1)/8 of each digit period.
- an  out  8  anodes, active low. an[7:4] are held at 1.
- sseg  out  8  segments, active low, ordered {dp,g,f,e,d,c,b,a}.
- frame_tick  out  1  one-cycle pulse in the first cycle of each frame, i.e. when digit 0 begins.

## Operation
- Code map, showing sseg with dp off:
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90
  - A='-'→BF, B=blank→FF, C='H'→89, D='L'→C7, E='I'→CF, F='E'→86
- Decimal point: if dp_mask[i]=1, sseg[7]=0 while digit i is shown. This applies even when the digit itself is blank.
- Leading-zero suppression, active when blank_lz=1:
  - Digit i (i = 3..1) is blanked when its code is 0 and every higher digit is either 0 or B.
  - Digit 0 is never suppressed.
  - Example: 16'h0050 displays "  50".
- Buffering:
  - update writes the pending register. Several updates within one frame: the last one wins.
  - At each frame boundary, the pending register is copied to the active register only if an update occurred since the previous boundary.
  - An update on the boundary cycle itself bypasses the pending register and is used by the frame that is starting.
- Scan:
  - A slice counter runs from 0 to SLICE_CYCLES-1.
  - A 3-bit slice index runs 0..7.
  - A 2-bit digit index runs 0,1,2,3, then wraps to 0; the wrap is the frame boundary.
- Brightness:
  - Digit i is lit (an[i]=0, decoded sseg) while slice index ≤ brightness.
  - Otherwise an=FF and sseg=FF.
  - brightness is sampled live at each slice start, not buffered.
- Ghost suppression: all anodes are high for the first cycle of every digit period, so only one anode is low at any time.

## Timing
- Reset values:
  - an=8'hFF, sseg=8'hFF, frame_tick=0
  - active and pending data = 16'hBBBB, dp masks 0, blank_lz 0
  - all counters 0, pending-valid flag 0
- Reset mid-frame blanks the outputs immediately (asynchronous). Scanning restarts at digit 0 on the first clk edge after rst_n rises.
- an, sseg and frame_tick are registered and reflect counter state with 1 cycle of latency.
- After reset release:
  - frame_tick first pulses on cycle 1.
  - Digit 0 first lights on cycle 2, because cycle 1 is the ghost-blank cycle.
- update latency:
  - An update at cycle t becomes visible at the first frame boundary b ≥ t, output 1 cycle after b (plus the ghost cycle before digit 0 lights).
  - Worst case is one frame: 32·SLICE_CYCLES cycles.
- Digit period is 8·SLICE_CYCLES cycles and frame period is 32·SLICE_CYCLES cycles. With brightness=7, each digit is lit for 8·SLICE_CYCLES−1 cycles.

## Structure
- Package sseg_pkg holds:
  - code constants CODE_DASH=4'hA, CODE_BLANK=4'hB, CODE_H=4'hC, CODE_L=4'hD, CODE_I=4'hE, CODE_E=4'hF
  - SEG_OFF=8'hFF
  - the display_word_t typedef (16-bit)
- Sub-module sseg_decode: combinational mapping of (code[3:0], dp) to sseg[7:0]. The leading-zero logic stays in the top level.
- The top level contains the counters, the double buffer and the output registers.

## Test plan
All scenarios use SLICE_CYCLES=4.
- Reset: hold rst_n=0 → an=FF, sseg=FF. Release → frame_tick on cycle 1; digit 0 shows FF (the buffer is still BBBB).
- Apply update with display_data=16'hCEBB, brightness=7 → in the next frame:
  - an=FE shows FF, an=FD shows FF
  - an=FB shows CF, an=F7 shows 89
  - each digit lit for 31 cycles
  - an[7:4] always 1
- Apply blank_lz=1 and data 16'h0050, then data 16'h0000 → first shows FF, FF, 92, C0 (digits 3..0); second shows only digit 0 as C0. Also check dp_mask=4'b0100 → digit 2 outputs 7F.
- Apply 16'h1000 mid-frame and 16'h9999 two cycles later → the current frame keeps the old data; the next frame shows 9999 (90 on every digit).
- Pulse update exactly on the frame-boundary cycle → the new data is shown in the frame that is starting.
- Set brightness=0 → each digit is lit for cycles 1..3 of its 32-cycle period and dark otherwise.
- Pulse rst_n low mid-digit → outputs go FF asynchronously; buffers return to BBBB.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package sseg_pkg;

  // Panel glyph codes above the decimal digits.
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [3:0] CODE_H     = 4'hC;
  localparam logic [3:0] CODE_L     = 4'hD;
  localparam logic [3:0] CODE_I     = 4'hE;
  localparam logic [3:0] CODE_E     = 4'hF;

  // All segments (and the decimal point) off, active low.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef logic [15:0] display_word_t;

  // One buffered display image: code word, decimal points, zero suppression.
  typedef struct packed {
    display_word_t data;
    logic [3:0]    dp;
    logic          blank_lz;
  } disp_buf_t;

  localparam disp_buf_t BUF_RESET = '{data: 16'hBBBB, dp: 4'h0, blank_lz: 1'b0};

  // A higher digit that is 0 or blank lets a lower zero be suppressed.
  function automatic logic zero_or_blank(input logic [3:0] code);
    return (code == 4'h0) || (code == CODE_BLANK);
  endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Front-panel side of the scan driver: code word, strobe, options and pins.
// update is a single-cycle strobe with no back-pressure: the driver always
// accepts it, so there is no ready; data/dp_mask/blank_lz are sampled only
// in a cycle where update is high.
interface sseg_scan_driver_if;
  import sseg_pkg::*;

  display_word_t display_data;
  logic          update;
  logic [3:0]    dp_mask;
  logic          blank_lz;
  logic [2:0]    brightness;
  logic [7:0]    an;
  logic [7:0]    sseg;
  logic          frame_tick;

  modport master (
    output display_data, update, dp_mask, blank_lz, brightness,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  display_data, update, dp_mask, blank_lz, brightness,
    output an, sseg, frame_tick
  );
endinterface

// File: rtl/sseg_decode.sv
// Combinational digit/glyph code to active-low segment pattern {dp,g..a}.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] body;

  // Glyph lookup with the decimal point off; dp is merged into bit 7 after.
  always_comb begin
    body = SEG_OFF;
    case (code)
      4'h0:       body = 8'hC0;
      4'h1:       body = 8'hF9;
      4'h2:       body = 8'hA4;
      4'h3:       body = 8'hB0;
      4'h4:       body = 8'h99;
      4'h5:       body = 8'h92;
      4'h6:       body = 8'h82;
      4'h7:       body = 8'hF8;
      4'h8:       body = 8'h80;
      4'h9:       body = 8'h90;
      CODE_DASH:  body = 8'hBF;
      CODE_BLANK: body = SEG_OFF;
      CODE_H:     body = 8'h89;
      CODE_L:     body = 8'hC7;
      CODE_I:     body = 8'hCF;
      CODE_E:     body = 8'h86;
      default:    body = SEG_OFF;
    endcase
    seg = {~dp, body[6:0]};
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with double buffering,
// leading-zero suppression, decimal points and 8-level brightness.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int SLICE_CYCLES = 12500
) (
  input  logic              clk,
  input  logic              rst_n,
  sseg_scan_driver_if.slave bus
);

  localparam int CNT_W = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       slice_q, slice_d;
  logic [1:0]       digit_q, digit_d;
  logic [2:0]       bright_q, bright_d;
  disp_buf_t        act_q, act_d, pend_q, pend_d, in_buf;
  logic             pend_vld_q, pend_vld_d;
  logic [7:0]       an_q, an_d, sseg_q, sseg_d;
  logic             ft_q, ft_d;

  logic       slice_start, slice_end, digit_start, frame_start;
  logic [2:0] bright_eff;
  logic [3:0] cur_code, dec_code;
  logic       dec_dp, higher_clear, lit;
  logic [7:0] dec_seg;

  assign in_buf = '{data: bus.display_data, dp: bus.dp_mask, blank_lz: bus.blank_lz};

  // Scan counters: cycle-in-slice, slice-in-digit, digit-in-frame.
  always_comb begin
    slice_start = (cnt_q == '0);
    slice_end   = (cnt_q == CNT_LAST);
    digit_start = slice_start && (slice_q == 3'd0);
    frame_start = digit_start && (digit_q == 2'd0);
    cnt_d       = slice_end ? '0 : cnt_q + 1'b1;
    slice_d     = slice_end ? slice_q + 3'd1 : slice_q;
    digit_d     = (slice_end && slice_q == 3'd7) ? digit_q + 2'd1 : digit_q;
    // Brightness is taken live at each slice start and held for the slice.
    bright_eff  = slice_start ? bus.brightness : bright_q;
    bright_d    = bright_eff;
  end

  // Double buffer: updates land in pending, promoted only at a frame start;
  // an update on the frame-start cycle goes straight to the active image.
  always_comb begin
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (frame_start) begin
      pend_vld_d = 1'b0;
      if (bus.update)      act_d = in_buf;
      else if (pend_vld_q) act_d = pend_q;
    end else if (bus.update) begin
      pend_d     = in_buf;
      pend_vld_d = 1'b1;
    end
  end

  // Current digit code with leading-zero suppression applied.
  always_comb begin
    cur_code = act_q.data[{digit_q, 2'b00} +: 4];
    case (digit_q)
      2'd2:    higher_clear = zero_or_blank(act_q.data[15:12]);
      2'd1:    higher_clear = zero_or_blank(act_q.data[15:12]) &&
                              zero_or_blank(act_q.data[11:8]);
      default: higher_clear = 1'b1;
    endcase
    dec_code = cur_code;
    if (act_q.blank_lz && digit_q != 2'd0 && cur_code == 4'h0 && higher_clear)
      dec_code = CODE_BLANK;
    dec_dp = act_q.dp[digit_q];
  end

  sseg_decode u_decode (
    .code (dec_code),
    .dp   (dec_dp),
    .seg  (dec_seg)
  );

  // Pin values for the next cycle; the first cycle of each digit stays dark
  // so two anodes are never low together across a digit change.
  always_comb begin
    lit    = !digit_start && (slice_q <= bright_eff);
    an_d   = lit ? {4'hF, ~(4'b0001 << digit_q)} : SEG_OFF;
    sseg_d = lit ? dec_seg : SEG_OFF;
    ft_d   = frame_start;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      slice_q    <= 3'd0;
      digit_q    <= 2'd0;
      bright_q   <= 3'd0;
      act_q      <= BUF_RESET;
      pend_q     <= BUF_RESET;
      pend_vld_q <= 1'b0;
      an_q       <= SEG_OFF;
      sseg_q     <= SEG_OFF;
      ft_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      slice_q    <= slice_d;
      digit_q    <= digit_d;
      bright_q   <= bright_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
      ft_q       <= ft_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_tick = ft_q;

endmodule
